// File: rtl/rx_edge_sampler_if.sv
// Signal bundle between the RX FSM side and the edge sampler.
// master drives the line and controls; slave returns counters and the voted bit.
interface rx_edge_sampler_if;
    logic       RX_IN;
    logic       enable;
    logic [5:0] prescale;
    logic [4:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       sampled_bit;
    logic       sample_done;
    logic       frame_done;

    modport master (
        output RX_IN,
        output enable,
        output prescale,
        input  edge_cnt,
        input  bit_cnt,
        input  sampled_bit,
        input  sample_done,
        input  frame_done
    );

    modport slave (
        input  RX_IN,
        input  enable,
        input  prescale,
        output edge_cnt,
        output bit_cnt,
        output sampled_bit,
        output sample_done,
        output frame_done
    );
endinterface

// File: rtl/rx_edge_sampler.sv
// UART RX timing stage: oversampling edge/bit counters plus a three-sample
// majority vote around mid-bit of the synchronised RX line.
module rx_edge_sampler #(
    parameter int unsigned FRAME_BITS  = 11,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic              CLK,
    input logic              RST,
    rx_edge_sampler_if.slave bus
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    logic [5:0] p_q;
    logic [5:0] p_sel;
    logic [5:0] p_last;
    logic [5:0] mid;
    logic [5:0] edge_ext;
    logic [3:0] last_bit;

    logic [4:0] edge_q, edge_d;
    logic [3:0] bit_q, bit_d;
    logic       s0_q, s0_d;
    logic       s1_q, s1_d;
    logic       sb_q, sb_d;
    logic       sd_q, sd_d;
    logic       fd_q, fd_d;

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign p_last   = p_q - 6'd1;
    assign mid      = p_q >> 1;
    assign edge_ext = {1'b0, edge_q};
    assign last_bit = 4'(FRAME_BITS - 1);

    // Unsupported ratios fall back to x8 rather than producing an odd period.
    always_comb begin
        p_sel = 6'd8;
        if (bus.prescale == 6'd8 || bus.prescale == 6'd16 || bus.prescale == 6'd32) begin
            p_sel = bus.prescale;
        end
    end

    always_comb begin
        edge_d = edge_q;
        bit_d  = bit_q;
        s0_d   = s0_q;
        s1_d   = s1_q;
        sb_d   = sb_q;
        sd_d   = 1'b0;
        fd_d   = 1'b0;

        if (!bus.enable) begin
            edge_d = 5'd0;
            bit_d  = 4'd0;
        end else begin
            if (edge_ext == p_last) begin
                edge_d = 5'd0;
                if (bit_q == last_bit) begin
                    bit_d = 4'd0;
                    fd_d  = 1'b1;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end else begin
                edge_d = edge_q + 5'd1;
            end

            if (edge_ext == mid - 6'd1) begin
                s0_d = rx_s;
            end
            if (edge_ext == mid) begin
                s1_d = rx_s;
            end
            if (edge_ext == mid + 6'd1) begin
                sb_d = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
                sd_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= '1;
            p_q    <= 6'd8;
            edge_q <= 5'd0;
            bit_q  <= 4'd0;
            s0_q   <= 1'b1;
            s1_q   <= 1'b1;
            sb_q   <= 1'b1;
            sd_q   <= 1'b0;
            fd_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.RX_IN};
            // Ratio is frozen for the whole enabled window.
            if (!bus.enable) begin
                p_q <= p_sel;
            end
            edge_q <= edge_d;
            bit_q  <= bit_d;
            s0_q   <= s0_d;
            s1_q   <= s1_d;
            sb_q   <= sb_d;
            sd_q   <= sd_d;
            fd_q   <= fd_d;
        end
    end

    assign bus.edge_cnt    = edge_q;
    assign bus.bit_cnt     = bit_q;
    assign bus.sampled_bit = sb_q;
    assign bus.sample_done = sd_q;
    assign bus.frame_done  = fd_q;

endmodule

// File: tb/tb_rx_edge_sampler.sv
// Bench for rx_edge_sampler: directed scenarios plus random runs, all outputs
// compared every cycle against a cycle-count based reference model.
module tb_rx_edge_sampler;
    localparam int FB = 11;
    localparam int S  = 2;
    localparam int HMAX = 16384;

    logic CLK = 1'b0;
    logic RST;

    rx_edge_sampler_if bus ();

    rx_edge_sampler #(
        .FRAME_BITS (FB),
        .SYNC_STAGES(S)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Reference model: line history plus count of enabled cycles in the run.
    int hist [0:HMAX-1];
    int cyc  = 0;
    int m_p  = 8;
    int m_n  = 0;
    int m_sb = 1;
    int m_sd = 0;
    int m_fd = 0;
    int rx_plan[$];

    function automatic int legal_p(input int ps);
        return (ps == 8 || ps == 16 || ps == 32) ? ps : 8;
    endfunction

    function automatic int line_at(input int k);
        return (k < 0) ? 1 : hist[k];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit en, input int ps);
        int rx;
        int e;
        int votes;
        rx = (rx_plan.size() > 0) ? rx_plan.pop_front() : 1;
        RST          = rst;
        bus.enable   = en;
        bus.prescale = 6'(ps);
        bus.RX_IN    = rx[0];
        if (cyc >= HMAX) begin
            $display("FAIL history_overflow: observed %0d expected < %0d", cyc, HMAX);
            $fatal(1, "bench history exhausted");
        end
        if (rst) begin
            for (int k = cyc - S + 1; k <= cyc; k++) begin
                if (k >= 0) hist[k] = 1;
            end
            m_n = 0; m_p = 8; m_sb = 1; m_sd = 0; m_fd = 0;
        end else begin
            hist[cyc] = rx;
            if (!en) begin
                m_p = legal_p(ps); m_n = 0; m_sd = 0; m_fd = 0;
            end else begin
                e = m_n % m_p;
                m_sd = (e == m_p / 2 + 1) ? 1 : 0;
                if (m_sd == 1) begin
                    votes = line_at(cyc - 2 - S) + line_at(cyc - 1 - S) + line_at(cyc - S);
                    m_sb = (votes >= 2) ? 1 : 0;
                end
                m_fd = ((m_n + 1) % (m_p * FB) == 0) ? 1 : 0;
                m_n++;
            end
        end
        cyc++;
        @(posedge CLK);
        @(negedge CLK);
        check("edge_cnt", 32'(bus.edge_cnt), 32'(m_n % m_p));
        check("bit_cnt", 32'(bus.bit_cnt), 32'((m_n / m_p) % FB));
        check("sampled_bit", 32'(bus.sampled_bit), 32'(m_sb));
        check("sample_done", 32'(bus.sample_done), 32'(m_sd));
        check("frame_done", 32'(bus.frame_done), 32'(m_fd));
    endtask

    function automatic int maj_want(input int n);
        if (n == 7 || n == 9 || n == 25) return 1;
        if (n == 8 || n == 23 || n == 24) return 0;
        return (n < 16) ? 0 : 1;
    endfunction

    initial begin
        int sd_cnt;
        int fd_cnt;
        int fd_at;
        int seen[$];
        int fbits[11];
        int ps_opts[6];
        int sb_before;
        int len;
        int ps;

        fbits   = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
        ps_opts = '{8, 16, 32, 12, 0, 63};
        RST = 1'b1; bus.enable = 1'b0; bus.prescale = 6'd8; bus.RX_IN = 1'b0;
        @(negedge CLK);

        // Reset with the line held low
        rx_plan.push_back(0); rx_plan.push_back(0);
        step(1, 0, 8);
        step(1, 0, 8);
        check("rst_edge_cnt", 32'(bus.edge_cnt), 32'd0);
        check("rst_bit_cnt", 32'(bus.bit_cnt), 32'd0);
        check("rst_sampled_bit", 32'(bus.sampled_bit), 32'd1);
        check("rst_sample_done", 32'(bus.sample_done), 32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        step(0, 0, 8);

        // Full frame at P=8
        sd_cnt = 0; fd_cnt = 0; fd_at = -1;
        for (int i = 1; i <= 88; i++) begin
            step(0, 1, 8);
            if (bus.sample_done) begin
                sd_cnt++;
                check("sd_at_edge6", 32'(bus.edge_cnt), 32'd6);
            end
            if (bus.frame_done) begin
                fd_cnt++;
                fd_at = i;
            end
        end
        check("p8_frame_done_count", 32'(fd_cnt), 32'd1);
        check("p8_frame_done_cycle", 32'(fd_at), 32'd88);
        check("p8_sample_done_count", 32'(sd_cnt), 32'd11);

        // Majority vote at P=16; plan leads by the synchroniser depth
        for (int k = 0; k < 34; k++) rx_plan.push_back(maj_want(k + S - 1));
        step(0, 0, 16);
        seen.delete();
        for (int i = 0; i < 32; i++) begin
            step(0, 1, 16);
            if (m_n % 16 == 10) seen.push_back(int'(bus.sampled_bit));
        end
        rx_plan.delete();
        check("maj_count", 32'(seen.size()), 32'd2);
        if (seen.size() == 2) begin
            check("maj_101", 32'(seen[0]), 32'd1);
            check("maj_001", 32'(seen[1]), 32'd0);
        end

        // Serial frame 0, 0xA5 LSB-first, parity 0, stop 1 at P=32
        for (int k = 0; k < 353; k++) begin
            rx_plan.push_back((k + S - 1 < 352) ? fbits[(k + S - 1) / 32] : 1);
        end
        step(0, 0, 32);
        seen.delete();
        for (int i = 0; i < 352; i++) begin
            step(0, 1, 32);
            if (m_n % 32 == 18) seen.push_back(int'(bus.sampled_bit));
        end
        rx_plan.delete();
        check("frame_bit_count", 32'(seen.size()), 32'd11);
        for (int i = 0; i < 11 && i < seen.size(); i++) begin
            check("frame_bit", 32'(seen[i]), 32'(fbits[i]));
        end

        // Illegal ratio falls back to P=8
        step(0, 0, 12);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 12);
            if (bus.sample_done) check("ps12_vote_edge", 32'(bus.edge_cnt), 32'd6);
        end
        check("ps12_wrap_edge", 32'(bus.edge_cnt), 32'd0);
        check("ps12_wrap_bit", 32'(bus.bit_cnt), 32'd1);

        // Ratio change while enabled is ignored
        step(0, 0, 8);
        for (int i = 0; i < 4; i++) step(0, 1, 8);
        for (int i = 0; i < 20; i++) step(0, 1, 32);
        check("ps_hold_edge", 32'(bus.edge_cnt), 32'd0);
        check("ps_hold_bit", 32'(bus.bit_cnt), 32'd3);
        step(0, 0, 32);
        for (int i = 0; i < 32; i++) step(0, 1, 32);
        check("ps32_edge", 32'(bus.edge_cnt), 32'd0);
        check("ps32_bit", 32'(bus.bit_cnt), 32'd1);

        // Abort mid-bit at P=16
        for (int k = 0; k < 55; k++) rx_plan.push_back(int'($urandom_range(1, 0)));
        step(0, 0, 16);
        for (int i = 0; i < 53; i++) step(0, 1, 16);
        check("abort_pre_edge", 32'(bus.edge_cnt), 32'd5);
        check("abort_pre_bit", 32'(bus.bit_cnt), 32'd3);
        sb_before = m_sb;
        step(0, 0, 16);
        rx_plan.delete();
        check("abort_edge", 32'(bus.edge_cnt), 32'd0);
        check("abort_bit", 32'(bus.bit_cnt), 32'd0);
        check("abort_sd", 32'(bus.sample_done), 32'd0);
        check("abort_sb_hold", 32'(bus.sampled_bit), 32'(sb_before));

        // Random runs: ratios, lengths, line data, mid-run prescale noise, resets
        for (int r = 0; r < 25; r++) begin
            ps  = ps_opts[$urandom_range(5, 0)];
            len = int'($urandom_range(200, 1));
            for (int k = 0; k <= len; k++) rx_plan.push_back(int'($urandom_range(1, 0)));
            if ($urandom_range(4, 0) == 0) step(1, $urandom_range(1, 0) == 1, ps);
            step(0, 0, ps);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(150, 0) == 0) step(1, 1, ps);
                else step(0, 1, ($urandom_range(9, 0) == 0) ? ps_opts[$urandom_range(5, 0)] : ps);
            end
            rx_plan.delete();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rx_edge_sampler.md
Name: rx_edge_sampler

Overview:
Upstream timing and sampling stage of the UART receiver. It counts oversampling clock edges within each bit (edge_cnt) and bits within a frame (bit_cnt). It majority-votes three samples of the synchronised RX line around mid-bit and presents the result as sampled_bit, which the parity checker, deserializer and stop/start checkers consume. edge_cnt and bit_cnt also feed the RX FSM.

Parameters:
FRAME_BITS, 11, bits per frame including start, data, parity and stop (legal range 2..15)
SYNC_STAGES, 2, flops in the RX_IN synchroniser (legal range 2..3)

Ports:
CLK  input  1  oversampling clock (prescale x baud)
RST  input  1  synchronous, active-high reset
RX_IN  input  1  asynchronous serial line, idle high
enable  input  1  count/sample enable from RX FSM
prescale  input  6  oversampling ratio; legal values 8, 16, 32
edge_cnt  output  5  edge index within current bit, 0..P-1
bit_cnt  output  4  bit index within frame, 0..FRAME_BITS-1
sampled_bit  output  1  majority-voted bit value
sample_done  output  1  one-cycle pulse when sampled_bit updates
frame_done  output  1  one-cycle pulse on last edge of last bit

Behaviour:
- Reset (RST=1 at a CLK rising edge) sets: edge_cnt=0, bit_cnt=0, sampled_bit=1, sample_done=0, frame_done=0, all synchroniser flops=1, vote sample regs s0/s1=1, P=8.
- Synchroniser: RX_IN runs through SYNC_STAGES flops every cycle regardless of enable. rx_s is the last stage. Line-to-rx_s latency is SYNC_STAGES cycles.
- Prescale latch P: loaded from prescale on every cycle where enable=0. Held constant while enable=1, so changes mid-frame are ignored. Any value other than 8, 16 or 32 latches as 8.
- Mid point M = P/2, giving M=4, 8 or 16.
- enable=0: edge_cnt and bit_cnt are forced to 0 on the next edge. sample_done and frame_done are 0. sampled_bit holds its value.
- enable=1, edge counter: edge_cnt increments each cycle.
  - When edge_cnt==P-1 it wraps to 0 and bit_cnt increments.
  - When edge_cnt==P-1 and bit_cnt==FRAME_BITS-1, both wrap to 0 and frame_done pulses high for the following cycle.
- Vote, on a cycle with enable=1, using the pre-edge value of edge_cnt:
  - edge_cnt==M-1: s0 <= rx_s.
  - edge_cnt==M: s1 <= rx_s.
  - edge_cnt==M+1: sampled_bit <= majority(s0, s1, rx_s), and sample_done <= 1 for exactly one cycle.
- Timing contract: sampled_bit is valid and stable from the cycle where edge_cnt==M+2 until the next vote. That cycle is edge 6 for P=8, 10 for P=16 and 18 for P=32, which is the downstream checkers' sampling point.
- Outputs are all registered; there are no combinational paths from inputs to outputs.
- Simultaneous events: frame_done and sample_done never coincide, because M+1 < P-1 for every legal P.
- enable falling mid-bit: counters clear on the next edge. A partial vote is discarded: s0/s1 are kept but overwritten by the next frame, and sampled_bit is not updated.
- Reset mid-frame: all state returns to reset values on that edge. Reset dominates enable.

Test Plan:
- Reset: RST=1 for 2 cycles with RX_IN=0 -> edge_cnt=0, bit_cnt=0, sampled_bit=1, sample_done=0, frame_done=0.
- Counting, P=8: enable=1 for 88 cycles with FRAME_BITS=11.
  - edge_cnt cycles 0..7.
  - bit_cnt steps 0..10, then returns to 0.
  - frame_done pulses exactly once, after cycle 88.
  - sample_done pulses 11 times, each visible at edge_cnt==6.
- Majority vote, P=16: drive rx_s=1,0,1 at edge_cnt 7,8,9 -> sampled_bit=1 at edge_cnt 10. Drive 0,0,1 -> sampled_bit=0.
- Frame data, P=32: send the serial frame 0, 0xA5 LSB-first, parity 0, 1 -> the sampled_bit sequence at edge_cnt==18 matches the frame bits exactly.
- Prescale handling:
  - prescale=12 latched -> behaves as P=8 (wrap at 7, vote at 6).
  - Changing prescale 8->32 while enable=1 -> period stays 8 until enable drops.
- Abort: drop enable at edge_cnt=5, bit_cnt=3 with P=16 -> the next cycle shows edge_cnt=0 and bit_cnt=0. sampled_bit is unchanged and there is no sample_done pulse.
